// File: rtl/seq_mul.sv
// seq_mul: sequential signed multiplier using radix-2 Booth recoding.
// One partial product is retired per clock. A start request is accepted
// in IDLE or DONE. The product and ready appear WIDTH+1 edges after the
// capture edge: WIDTH Booth iterations, then one completion edge.
// Optional feature: define SEQ_MUL_BUSY_EN to add a 'busy' output.
// busy is high only while the machine is in CALC and is never high
// while reset is asserted.
module seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               ready,
  output logic [2*WIDTH-1:0] out
`ifdef SEQ_MUL_BUSY_EN
  ,
  output logic               busy
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     mcand_reg, mcand_next;
  logic [WIDTH:0]       acc_reg, acc_next;
  logic [WIDTH-1:0]     q_reg, q_next;
  logic                 q_m1_reg, q_m1_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   out_reg, out_next;
  logic                 ready_reg, ready_next;

  logic [WIDTH:0]       mcand_ext;
  logic [WIDTH:0]       sum;

  assign ready = ready_reg;
  assign out   = out_reg;

`ifdef SEQ_MUL_BUSY_EN
  assign busy = (state_reg == CALC) && !reset;
`endif

  // Booth step: add or subtract the sign-extended multiplicand based on {q0, q-1}
  always_comb begin
    mcand_ext = {mcand_reg[WIDTH-1], mcand_reg};
    sum       = acc_reg;
    case ({q_reg[0], q_m1_reg})
      2'b01:   sum = acc_reg + mcand_ext;
      2'b10:   sum = acc_reg - mcand_ext;
      default: sum = acc_reg;
    endcase
  end

  // Next-state and datapath update for the IDLE/CALC/DONE controller
  always_comb begin
    state_next = state_reg;
    mcand_next = mcand_reg;
    acc_next   = acc_reg;
    q_next     = q_reg;
    q_m1_next  = q_m1_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    ready_next = ready_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          mcand_next = A;
          q_next     = B;
          q_m1_next  = 1'b0;
          acc_next   = '0;
          cnt_next   = '0;
          ready_next = 1'b0;
          state_next = CALC;
        end
      end
      CALC: begin
        if (cnt_reg == CW'(WIDTH)) begin
          // All iterations retired: the low 2*WIDTH bits of {acc, q} hold the exact product
          out_next   = {acc_reg[WIDTH-1:0], q_reg};
          ready_next = 1'b1;
          state_next = DONE;
        end else begin
          // Arithmetic shift of {acc, q, q-1} right by one
          acc_next  = {sum[WIDTH], sum[WIDTH:1]};
          q_next    = {sum[0], q_reg[WIDTH-1:1]};
          q_m1_next = q_reg[0];
          cnt_next  = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      mcand_reg <= '0;
      acc_reg   <= '0;
      q_reg     <= '0;
      q_m1_reg  <= 1'b0;
      cnt_reg   <= '0;
      out_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      mcand_reg <= mcand_next;
      acc_reg   <= acc_next;
      q_reg     <= q_next;
      q_m1_reg  <= q_m1_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      ready_reg <= ready_next;
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: self-checking bench for seq_mul (WIDTH=16).
// A table of directed vectors, hand-written multi-cycle sequences and
// back-to-back random operations. Expected products are queued when a
// start is driven and popped when ready rises.
module tb_seq_mul;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           ready;
  logic [2*W-1:0] out;
`ifdef SEQ_MUL_BUSY_EN
  logic           busy;
`endif

  always #5 clk = ~clk;

  seq_mul #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .ready (ready),
    .out   (out)
`ifdef SEQ_MUL_BUSY_EN
    ,
    .busy  (busy)
`endif
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t           vecs[8];
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_p;
  logic [W-1:0]   cur_a;
  logic [W-1:0]   cur_b;
  int             n_cmp = 0;
  int             n_err = 0;
  int             n_op  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // Drive one start pulse and queue the expected product; returns 1ns after the capture edge
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    cur_a = a;
    cur_b = b;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ready_drop_on_start", {63'd0, ready}, 64'd0);
    chk("out_held_on_start", {32'd0, out}, {32'd0, last_p});
`ifdef SEQ_MUL_BUSY_EN
    chk("busy_in_calc", {63'd0, busy}, 64'd1);
`endif
  endtask

  // Wait (bounded) for ready, check latency, then pop and compare the product
  task automatic finish_op(input int pre_edges, input string tag);
    int edges;
    logic [2*W-1:0] p;
    edges = pre_edges;
    while (ready !== 1'b1 && edges < 64) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, "_latency"}, 64'(edges), 64'(W + 1));
`ifdef SEQ_MUL_BUSY_EN
    chk({tag, "_busy_low_done"}, {63'd0, busy}, 64'd0);
`endif
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_scoreboard: got empty queue, expected one entry", tag);
    end else begin
      p = exp_q.pop_front();
      chk({tag, "_product"}, {32'd0, out}, {32'd0, p});
      last_p = p;
    end
    n_op++;
    $display("op %0d %s: A=%0d B=%0d out=0x%h latency=%0d", n_op, tag,
             $signed(cur_a), $signed(cur_b), out, edges);
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{16'd15,    16'd3,     32'd45};
    vecs[1] = '{16'hFFFB,  16'd7,     32'hFFFFFFDD};
    vecs[2] = '{16'd8,     16'hFFFC,  32'hFFFFFFE0};
    vecs[3] = '{16'hFFFA,  16'hFFFB,  32'd30};
    vecs[4] = '{16'h8000,  16'h8000,  32'h40000000};
    vecs[5] = '{16'h8000,  16'd1,     32'hFFFF8000};
    vecs[6] = '{16'd0,     16'hFFFF,  32'd0};
    vecs[7] = '{16'h7FFF,  16'h7FFF,  32'h3FFF0001};

    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    last_p = '0;
    cur_a = '0;
    cur_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_out", {32'd0, out}, 64'd0);
`ifdef SEQ_MUL_BUSY_EN
    chk("reset_busy", {63'd0, busy}, 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // First operation, then confirm out and ready hold while idle in DONE
    launch(16'd15, 16'd3);
    finish_op(0, "first");
    repeat (5) @(posedge clk);
    #1;
    chk("hold_ready", {63'd0, ready}, 64'd1);
    chk("hold_out", {32'd0, out}, 64'd45);

    // Directed table: the expected products are written as literals in vecs
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      A = vecs[i].a;
      B = vecs[i].b;
      start = 1'b1;
      cur_a = vecs[i].a;
      cur_b = vecs[i].b;
      exp_q.push_back(vecs[i].p);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("table_ready_drop", {63'd0, ready}, 64'd0);
      chk("table_out_held", {32'd0, out}, {32'd0, last_p});
      finish_op(0, "table");
    end

    // Operands change and start pulses while in CALC: both must be ignored
    launch(16'd123, 16'hFFD3);
    @(posedge clk);
    #1;
    A = 16'h1234;
    B = 16'h4321;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 16'hFFFF;
    B = 16'h8000;
    finish_op(2, "midcalc");
    chk("midcalc_value", {32'd0, out}, 64'hFFFFEA61);

    // Back-to-back random operations, each started the cycle after ready rises
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      launch(ra, rb);
      finish_op(0, "rand");
    end

    // Reset five cycles into CALC aborts the operation with no ready pulse
    launch(16'd100, 16'd100);
    void'(exp_q.pop_back());
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", {63'd0, ready}, 64'd0);
    chk("abort_out", {32'd0, out}, 64'd0);
    last_p = '0;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (24) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) seen++;
    end
    chk("abort_no_ready", 64'(seen), 64'd0);
    launch(16'd2, 16'd3);
    finish_op(0, "after_abort");
    chk("after_abort_value", {32'd0, out}, 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
